// File: rtl/adc_lvds_tx.sv
// ---------------------------------------------------------------------------
// adc_lvds_tx
// Emulates the serial LVDS output side of the ADC so the deserializer and
// capture path can be exercised without the real converter. Each frame
// carries one WORD_W-bit sample per lane, MSB first, one bit per clk_50
// cycle. bit_clk (clk_50/2) and frame_clk (clk_50/WORD_W) are generated
// edge-aligned to the data.
//
// Ports:
//   clk_50        system clock, one serial bit per cycle
//   reset_n       asynchronous active-low reset
//   enable        start / continue streaming
//   pattern_mode  0=upstream, 1=ramp, 2=sync, 3=deskew (sampled at word load)
//   sample_data   upstream word, lane k = [k*WORD_W +: WORD_W]
//   sample_valid  upstream word valid
//   sample_ready  hold register empty
//   bit_clk       serial bit clock
//   frame_clk     frame clock, high for the first WORD_W/2 bits
//   lvds_pins     serial data lanes
//   busy          high while streaming
//   underrun_cnt  saturating count of data-mode loads with no word held
//   frame_cnt     frames started (wraps)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module adc_lvds_tx #(
    parameter int                LANES      = 8,
    parameter int                WORD_W     = 12,
    parameter logic [WORD_W-1:0] SYNC_PAT   = 12'hFC0,
    parameter logic [WORD_W-1:0] DESKEW_PAT = 12'hAAA
) (
    input  logic                      clk_50,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [1:0]                pattern_mode,
    input  logic [LANES*WORD_W-1:0]   sample_data,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic                      bit_clk,
    output logic                      frame_clk,
    output logic [LANES-1:0]          lvds_pins,
    output logic                      busy,
    output logic [15:0]               underrun_cnt,
    output logic [31:0]               frame_cnt
);

    localparam int DATA_W = LANES * WORD_W;
    localparam int CNT_W  = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(WORD_W / 2);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_nxt_s;
    logic               load_s;

    logic [DATA_W-1:0]  word_r, word_nxt_s;
    logic [DATA_W-1:0]  hold_r, hold_nxt_s;
    logic               hold_full_r, hold_full_nxt_s;
    logic [DATA_W-1:0]  last_word_r, last_word_nxt_s;
    logic [WORD_W-1:0]  ramp_r, ramp_nxt_s, ramp_base_s;
    logic [15:0]        underrun_r, underrun_nxt_s;
    logic [31:0]        frame_r, frame_nxt_s;

    logic [LANES-1:0]   pins_nxt_s;
    logic [WORD_W-1:0]  lane_w_s;
    logic               run_nxt_s;

    // State register: FSM state and bit position within the frame.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
        end
    end

    // Next-state logic: a word is loaded on IDLE->RUN and at every frame end while enabled.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = '0;
        load_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bit_cnt_r == LAST_BIT) begin
                    if (enable) begin
                        load_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Word source selection, hold-register handshake and statistics counters.
    always_comb begin
        word_nxt_s      = word_r;
        hold_nxt_s      = hold_r;
        hold_full_nxt_s = hold_full_r;
        last_word_nxt_s = last_word_r;
        ramp_nxt_s      = ramp_r;
        underrun_nxt_s  = underrun_r;
        frame_nxt_s     = frame_r;
        // The ramp restarts from zero whenever streaming starts from IDLE.
        ramp_base_s     = (state_r == ST_IDLE) ? '0 : ramp_r;

        if (load_s) begin
            frame_nxt_s = frame_r + 32'd1;
            ramp_nxt_s  = ramp_base_s;
            case (pattern_mode)
                2'd0: begin
                    if (hold_full_r) begin
                        word_nxt_s      = hold_r;
                        last_word_nxt_s = hold_r;
                        hold_full_nxt_s = 1'b0;
                    end else begin
                        word_nxt_s     = last_word_r;
                        underrun_nxt_s = (underrun_r == 16'hFFFF) ? underrun_r : underrun_r + 16'd1;
                    end
                end
                2'd1: begin
                    word_nxt_s = {LANES{ramp_base_s}};
                    ramp_nxt_s = ramp_base_s + WORD_W'(1);
                end
                2'd2: begin
                    word_nxt_s = {LANES{SYNC_PAT}};
                end
                2'd3: begin
                    word_nxt_s = {LANES{DESKEW_PAT}};
                end
                default: begin
                    word_nxt_s = word_r;
                end
            endcase
        end else begin
            word_nxt_s = word_r;
        end

        // Accept only when the hold register was empty at the start of the cycle.
        if (sample_valid && !hold_full_r) begin
            hold_nxt_s      = sample_data;
            hold_full_nxt_s = 1'b1;
        end else begin
            hold_nxt_s = hold_r;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            word_r      <= '0;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            last_word_r <= '0;
            ramp_r      <= '0;
            underrun_r  <= 16'd0;
            frame_r     <= 32'd0;
        end else begin
            word_r      <= word_nxt_s;
            hold_r      <= hold_nxt_s;
            hold_full_r <= hold_full_nxt_s;
            last_word_r <= last_word_nxt_s;
            ramp_r      <= ramp_nxt_s;
            underrun_r  <= underrun_nxt_s;
            frame_r     <= frame_nxt_s;
        end
    end

    // Output decode from next-state values so the registered pins show bit n while bit_cnt=n.
    always_comb begin
        pins_nxt_s = '0;
        lane_w_s   = '0;
        run_nxt_s  = (state_nxt_s == ST_RUN);
        for (int k = 0; k < LANES; k++) begin
            lane_w_s = word_nxt_s[k*WORD_W +: WORD_W];
            if (run_nxt_s) begin
                pins_nxt_s[k] = lane_w_s[LAST_BIT - bit_cnt_nxt_s];
            end else begin
                pins_nxt_s[k] = 1'b0;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            lvds_pins    <= '0;
            bit_clk      <= 1'b0;
            frame_clk    <= 1'b0;
            busy         <= 1'b0;
            sample_ready <= 1'b1;
        end else begin
            lvds_pins    <= pins_nxt_s;
            bit_clk      <= run_nxt_s & bit_cnt_nxt_s[0];
            frame_clk    <= run_nxt_s & (bit_cnt_nxt_s < HALF_BIT);
            busy         <= run_nxt_s;
            sample_ready <= ~hold_full_nxt_s;
        end
    end

    assign underrun_cnt = underrun_r;
    assign frame_cnt    = frame_r;

endmodule

// File: tb/tb_adc_lvds_tx.sv
`timescale 1ns/1ps
module tb_adc_lvds_tx;

    localparam int LANES  = 8;
    localparam int WORD_W = 12;
    localparam int DATA_W = LANES * WORD_W;
    localparam int NVEC   = 10;

    logic              clk_50 = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [1:0]        pattern_mode;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              bit_clk;
    logic              frame_clk;
    logic [LANES-1:0]  lvds_pins;
    logic              busy;
    logic [15:0]       underrun_cnt;
    logic [31:0]       frame_cnt;

    adc_lvds_tx dut (
        .clk_50       (clk_50),
        .reset_n      (reset_n),
        .enable       (enable),
        .pattern_mode (pattern_mode),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bit_clk      (bit_clk),
        .frame_clk    (frame_clk),
        .lvds_pins    (lvds_pins),
        .busy         (busy),
        .underrun_cnt (underrun_cnt),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk_50 = ~clk_50;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] all_lanes(input logic [WORD_W-1:0] w);
        return {LANES{w}};
    endfunction

    function automatic logic [DATA_W-1:0] lanes_inc(input logic [WORD_W-1:0] base);
        logic [DATA_W-1:0] d;
        for (int k = 0; k < LANES; k++) d[k*WORD_W +: WORD_W] = base + WORD_W'(k);
        return d;
    endfunction

    function automatic logic [LANES-1:0] lane_msbs(input logic [DATA_W-1:0] w);
        logic [LANES-1:0] m;
        for (int k = 0; k < LANES; k++) m[k] = w[k*WORD_W + WORD_W - 1];
        return m;
    endfunction

    // Scoreboard of expected frame words, in transmit order.
    logic [DATA_W-1:0] exp_q[$];

    // Deserializer model: rebuilds each frame, checks clocks and frame counter.
    logic [WORD_W-1:0] lane_acc [LANES];
    int pos        = 0;
    int bit_idx    = -1;
    int started    = 0;
    int exp_frames = 0;

    always @(negedge clk_50) begin
        logic [DATA_W-1:0] got;
        logic [DATA_W-1:0] expw;
        if (!reset_n) begin
            pos        = 0;
            bit_idx    = -1;
            exp_frames = 0;
            exp_q.delete();
        end else if (busy) begin
            if (pos == 0) begin
                started++;
                exp_frames++;
                chk("frame_cnt", 96'(frame_cnt), 96'(exp_frames));
            end
            chk("clocks", 96'({bit_clk, frame_clk}), 96'({(pos % 2) == 1, pos < WORD_W/2}));
            for (int k = 0; k < LANES; k++) lane_acc[k] = {lane_acc[k][WORD_W-2:0], lvds_pins[k]};
            bit_idx = pos;
            pos++;
            if (pos == WORD_W) begin
                for (int k = 0; k < LANES; k++) got[k*WORD_W +: WORD_W] = lane_acc[k];
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", got, '0);
                    if (got == '0) chk("unexpected_frame", 96'd1, 96'd0);
                end else begin
                    expw = exp_q.pop_front();
                    chk("frame_word", got, expw);
                end
                pos = 0;
            end
        end else begin
            chk("truncated_frame", 96'(pos), 96'd0);
            pos     = 0;
            bit_idx = -1;
            chk("idle_outputs", 96'({lvds_pins, bit_clk, frame_clk}), 96'd0);
        end
    end

    task automatic wait_started(input int n, input int budget);
        int c = 0;
        while (started < n && c < budget) begin
            @(negedge clk_50); #1;
            c++;
        end
        chk("wait_frame_timeout", 96'(started >= n), 96'd1);
    endtask

    // Drop enable once the current frame shows bit drop_pos, then wait for IDLE.
    task automatic go_idle(input int drop_pos);
        int c = 0;
        while (bit_idx != drop_pos && c < 30) begin
            @(negedge clk_50); #1;
            c++;
        end
        chk("drop_pos_timeout", 96'(bit_idx), 96'(drop_pos));
        enable = 1'b0;
        c = 0;
        while (busy && c < 30) begin
            @(negedge clk_50); #1;
            c++;
        end
        chk("busy_after_stop", 96'(busy), 96'd0);
        chk("queue_drained", 96'(exp_q.size()), 96'd0);
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        chk("ready_before_push", 96'(sample_ready), 96'd1);
        sample_data  = d;
        sample_valid = 1'b1;
        @(negedge clk_50); #1;
        sample_valid = 1'b0;
        chk("ready_after_accept", 96'(sample_ready), 96'd0);
    endtask

    typedef struct {
        logic [1:0]        mode;
        bit                push;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t vecs [NVEC];

    initial begin
        logic [DATA_W-1:0] rnd;
        int base;

        reset_n      = 1'b0;
        enable       = 1'b0;
        pattern_mode = 2'd0;
        sample_data  = '0;
        sample_valid = 1'b0;
        rnd = {$urandom(), $urandom(), $urandom()};

        repeat (3) @(negedge clk_50);
        #1;
        chk("rst_pins_clks", 96'({lvds_pins, bit_clk, frame_clk, busy}), 96'd0);
        chk("rst_ready", 96'(sample_ready), 96'd1);
        chk("rst_counters", 96'({underrun_cnt, frame_cnt}), 96'd0);
        reset_n = 1'b1;
        @(negedge clk_50); #1;

        vecs[0] = '{2'd2, 1'b0, '0, all_lanes(12'hFC0)};
        vecs[1] = '{2'd3, 1'b0, '0, all_lanes(12'hAAA)};
        vecs[2] = '{2'd0, 1'b1, lanes_inc(12'h100), lanes_inc(12'h100)};
        vecs[3] = '{2'd0, 1'b1, all_lanes(12'hABC), all_lanes(12'hABC)};
        vecs[4] = '{2'd0, 1'b1, all_lanes(12'h5A5), all_lanes(12'h5A5)};
        vecs[5] = '{2'd0, 1'b0, '0, all_lanes(12'h5A5)};
        vecs[6] = '{2'd0, 1'b0, '0, all_lanes(12'h5A5)};
        vecs[7] = '{2'd1, 1'b0, '0, all_lanes(12'd0)};
        vecs[8] = '{2'd1, 1'b0, '0, all_lanes(12'd1)};
        vecs[9] = '{2'd0, 1'b1, rnd, rnd};

        // Continuous stream: each entry's stimulus is applied during the previous frame.
        base = started;
        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) wait_started(base + i, 40);
            pattern_mode = vecs[i].mode;
            if (vecs[i].push) push_word(vecs[i].data);
            exp_q.push_back(vecs[i].exp);
            if (i == 0) begin
                enable = 1'b1;
                @(negedge clk_50); #1;
                chk("latency_busy", 96'({busy, frame_clk, bit_clk}), 96'(3'b110));
                chk("latency_msb", 96'(lvds_pins), 96'(lane_msbs(vecs[0].exp)));
            end
        end
        wait_started(base + NVEC, 40);
        go_idle(1);
        chk("underrun_cnt", 96'(underrun_cnt), 96'd2);

        // Ramp through a full wrap.
        pattern_mode = 2'd1;
        for (int r = 0; r <= 4096; r++) exp_q.push_back(all_lanes(WORD_W'(r % 4096)));
        base = started;
        enable = 1'b1;
        wait_started(base + 4097, 52000);
        go_idle(1);

        // Re-enable restarts the ramp.
        exp_q.push_back(all_lanes(12'd0));
        exp_q.push_back(all_lanes(12'd1));
        base = started;
        enable = 1'b1;
        wait_started(base + 2, 40);
        go_idle(1);

        // Enable dropped at bit 3: frame completes, then an idle-pushed word goes first.
        pattern_mode = 2'd2;
        exp_q.push_back(all_lanes(12'hFC0));
        base = started;
        enable = 1'b1;
        wait_started(base + 1, 40);
        go_idle(3);
        pattern_mode = 2'd0;
        push_word(all_lanes(12'h3C7));
        repeat (5) @(negedge clk_50);
        #1;
        chk("idle_hold_busy", 96'({busy, sample_ready}), 96'd0);
        exp_q.push_back(all_lanes(12'h3C7));
        base = started;
        enable = 1'b1;
        wait_started(base + 1, 40);
        go_idle(1);
        chk("underrun_unchanged", 96'(underrun_cnt), 96'd2);

        // Asynchronous reset in the middle of a data-mode frame.
        push_word(lanes_inc(12'h7F0));
        exp_q.push_back(lanes_inc(12'h7F0));
        base = started;
        enable = 1'b1;
        wait_started(base + 1, 40);
        while (bit_idx != 7) begin
            @(negedge clk_50); #1;
        end
        reset_n = 1'b0;
        #1;
        chk("arst_outputs", 96'({lvds_pins, bit_clk, frame_clk, busy}), 96'd0);
        chk("arst_ready", 96'(sample_ready), 96'd1);
        chk("arst_counters", 96'({underrun_cnt, frame_cnt}), 96'd0);
        enable = 1'b0;
        repeat (2) @(negedge clk_50);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk_50);
        #1;
        chk("post_reset_idle", 96'({busy, sample_ready}), 96'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
